// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter: FSM states,
// digit constants and the bit-counter width helper.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } bcd_state_t;

  localparam int unsigned BCD_DIGIT_W    = 4;
  localparam int unsigned BCD_ADJ_THRESH = 5;
  localparam int unsigned BCD_ADJ_ADD    = 3;

  // Counter only has to reach BIN_W-1; keep at least one bit for BIN_W=1.
  function automatic int unsigned bcd_cnt_width(input int unsigned bin_w);
    return (bin_w < 2) ? 1 : $clog2(bin_w);
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Combinational double-dabble cell: adds 3 to a BCD digit that is 5 or more.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] din,
  output logic [BCD_DIGIT_W-1:0] dout
);

  always_comb begin
    dout = din;
    if (din >= BCD_DIGIT_W'(BCD_ADJ_THRESH))
      dout = din + BCD_DIGIT_W'(BCD_ADJ_ADD);
  end

endmodule

// File: rtl/binary_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock,
// valid/ready on both sides. Define BCD_OVF_EN to compile in the sticky overflow flag.
module binary_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = 14,
  parameter int unsigned DIGITS = 5
)(
  input  logic                            clk,
  input  logic                            rst,
  input  logic [BIN_W-1:0]                bin,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [BCD_DIGIT_W*DIGITS-1:0]   bcd,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            ovf
);

  localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int unsigned CNT_W = bcd_cnt_width(BIN_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BIN_W - 1);

  bcd_state_t       state;
  logic [BIN_W-1:0] sr;
  logic [BCD_W-1:0] acc;
  logic [BCD_W-1:0] adj;
  logic [BCD_W-1:0] acc_nx;
  logic [CNT_W-1:0] cnt;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (acc[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .dout (adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // The bit leaving the top digit is dropped here; the overflow logic taps it separately.
  assign acc_nx   = BCD_W'({adj, sr[BIN_W-1]});
  assign in_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sr        <= '0;
      acc       <= '0;
      cnt       <= '0;
      bcd       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sr    <= bin;
            acc   <= '0;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          acc <= acc_nx;
          sr  <= sr << 1;
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST_BIT) begin
            bcd       <= acc_nx;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BCD_OVF_EN
  logic ovf_st;
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_st <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      ovf_st <= 1'b0;
    end else if (state == SHIFT) begin
      ovf_st <= ovf_st | adj[BCD_W-1];
      if (cnt == LAST_BIT)
        ovf_q <= ovf_st | adj[BCD_W-1];
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// Self-checking bench for binary_to_bcd_seq: default 14-bit/5-digit instance plus
// a 4-digit instance for truncation/overflow behaviour (BCD_OVF_EN aware).
module tb_binary_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] bin;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] bcd;
  logic        out_valid;
  logic        out_ready;
  logic        ovf;

  logic [13:0] bin4;
  logic        in_valid4;
  logic        in_ready4;
  logic [15:0] bcd4;
  logic        out_valid4;
  logic        out_ready4;
  logic        ovf4;

  int checks = 0;
  int errors = 0;

  logic [20:0] exp_q[$];

  typedef struct {
    logic [13:0] bin;
    logic [19:0] bcd;
  } vec_t;

  vec_t vecs[8];

  binary_to_bcd_seq #(.BIN_W(14), .DIGITS(5)) dut (
    .clk(clk), .rst(rst), .bin(bin), .in_valid(in_valid), .in_ready(in_ready),
    .bcd(bcd), .out_valid(out_valid), .out_ready(out_ready), .ovf(ovf)
  );

  binary_to_bcd_seq #(.BIN_W(14), .DIGITS(4)) dut4 (
    .clk(clk), .rst(rst), .bin(bin4), .in_valid(in_valid4), .in_ready(in_ready4),
    .bcd(bcd4), .out_valid(out_valid4), .out_ready(out_ready4), .ovf(ovf4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int unsigned k = 0;
    while (!in_ready && k < 50) begin
      tick();
      k++;
    end
    if (!in_ready) chk("idle_timeout", 32'(in_ready), 32'd1);
  endtask

  // Convert one operand; hold = cycles of out_ready=0 in DONE, poke = pulse in_valid during SHIFT.
  task automatic run(input logic [13:0] b, input logic [19:0] expb, input int unsigned hold,
                     input bit poke);
    int unsigned k;
    bit busy_bad;
    bit hold_bad;
    logic [20:0] e;
    wait_idle();
    bin       = b;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    tick();
    in_valid = 1'b0;
    exp_q.push_back({1'b0, expb});
    k = 0;
    busy_bad = 1'b0;
    while (!out_valid && k < 40) begin
      if (in_ready) busy_bad = 1'b1;
      if (poke && k == 3) begin
        bin      = ~b;
        in_valid = 1'b1;
      end
      if (poke && k == 5) in_valid = 1'b0;
      tick();
      k++;
    end
    in_valid = 1'b0;
    if (in_ready) busy_bad = 1'b1;
    chk("latency", k, 32'd14);
    chk("in_ready_busy", 32'(busy_bad), 32'd0);
    if (!out_valid) return;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    chk("bcd", 32'(bcd), 32'(e[19:0]));
    chk("ovf", 32'(ovf), 32'(e[20]));
    hold_bad = 1'b0;
    for (int unsigned i = 0; i < hold; i++) begin
      tick();
      if (!out_valid || in_ready || bcd !== e[19:0]) hold_bad = 1'b1;
    end
    if (hold != 0) chk("backpressure_hold", 32'(hold_bad), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("idle_after_hs", {30'd0, in_ready, out_valid}, 32'b10);
    chk("bcd_held_idle", 32'(bcd), 32'(e[19:0]));
  endtask

  task automatic run4(input logic [13:0] b, input logic [15:0] expb, input logic expo);
    int unsigned k = 0;
    while (!in_ready4 && k < 50) begin
      tick();
      k++;
    end
    bin4       = b;
    in_valid4  = 1'b1;
    out_ready4 = 1'b0;
    tick();
    in_valid4 = 1'b0;
    k = 0;
    while (!out_valid4 && k < 40) begin
      tick();
      k++;
    end
    chk("d4_latency", k, 32'd14);
    chk("d4_bcd", 32'(bcd4), 32'(expb));
    chk("d4_ovf", 32'(ovf4), 32'(expo));
    out_ready4 = 1'b1;
    tick();
    out_ready4 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{14'd0,     20'h00000};
    vecs[1] = '{14'd4095,  20'h04095};
    vecs[2] = '{14'd2730,  20'h02730};
    vecs[3] = '{14'd16383, 20'h16383};
    vecs[4] = '{14'd1,     20'h00001};
    vecs[5] = '{14'd9999,  20'h09999};
    vecs[6] = '{14'd8191,  20'h08191};
    vecs[7] = '{14'd5555,  20'h05555};

    rst = 1'b1;
    bin = '0; in_valid = 1'b0; out_ready = 1'b0;
    bin4 = '0; in_valid4 = 1'b0; out_ready4 = 1'b0;
    tick();
    in_valid = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_bcd", 32'(bcd), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);

    for (int unsigned i = 0; i < 8; i++)
      run(vecs[i].bin, vecs[i].bcd, 0, 1'b0);

    run(14'd201, 20'h00201, 6, 1'b0);
    run(14'd1234, 20'h01234, 0, 1'b1);

    // Reset five cycles into SHIFT discards the operand
    wait_idle();
    bin = 14'd9999;
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    exp_q.push_back({1'b0, 20'h09999});
    for (int unsigned i = 0; i < 5; i++) tick();
    chk("mid_busy", 32'(in_ready), 32'd0);
    rst = 1'b1;
    bin = 14'd55;
    in_valid = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    exp_q.delete();
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_bcd", 32'(bcd), 32'd0);
    run(14'd10, 20'h00010, 0, 1'b0);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

`ifdef BCD_OVF_EN
    run4(14'd10000, 16'h0000, 1'b1);
    run4(14'd9999,  16'h9999, 1'b0);
    run4(14'd12345, 16'h2345, 1'b1);
`else
    run4(14'd12345, 16'h2345, 1'b0);
    run4(14'd9999,  16'h9999, 1'b0);
    run4(14'd10000, 16'h0000, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/binary_to_bcd_seq.md
# binary_to_bcd_seq

Sequential, parametrised binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one input bit per clock. It replaces the single-cycle combinational converter wherever the binary width or digit count would make a flat adder chain too deep. It sits between a binary counter or accumulator and the display/formatting logic, with valid/ready handshakes on both sides.

## Interface
- `BIN_W`, default 14: binary input width; must be ≥ 1.
- `DIGITS`, default 5: number of BCD output digits; output width is 4·DIGITS.
- `clk` input 1: clock; all state changes on the rising edge.
- `rst` input 1: reset; one clock; reset is synchronous and active-high.
- `bin` input BIN_W: unsigned binary operand; sampled only on an accepted transfer.
- `in_valid` input 1: operand present.
- `in_ready` output 1: converter idle and able to accept.
- `bcd` output 4·DIGITS: packed BCD result; digit 0 (ones) is in bits [3:0].
- `out_valid` output 1: `bcd` (and `ovf`) hold a completed result.
- `out_ready` input 1: consumer accepts the result.
- `ovf` output 1: result did not fit in DIGITS digits. Only meaningful with `BCD_OVF_EN`.

## Operation
- The FSM has three states: IDLE, SHIFT and DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`: load the shift register with `bin`, clear the BCD accumulator, clear the bit counter, clear the sticky overflow, then go to SHIFT.
- **SHIFT**
  - `in_ready`=0.
  - Each cycle, every digit ≥ 5 gets +3; then {accumulator, shift register} shifts left by 1 (MSB of `bin` first).
  - The bit counter increments each cycle. After the BIN_W-th shift the FSM goes to DONE.
- **DONE**
  - `out_valid`=1. `bcd` and `ovf` are held stable.
  - On `out_ready`, go to IDLE.
- `in_valid` is ignored outside IDLE. Operands arriving while busy are not queued; the source holds them per handshake.
- Arithmetic:
  - Each digit adjust is 4-bit: a value of 5..9 becomes 8..12.
  - Any bit shifted out of the top digit is an overflow event.
- When 10^DIGITS > 2^BIN_W − 1 the result is always exact, and `ovf` stays 0.
- `bcd` is updated only at the SHIFT→DONE transition. It holds the last result through IDLE until the next completion.

## Timing
- **Reset values**
  - state=IDLE, `bcd`=0, `out_valid`=0, `ovf`=0.
  - `in_ready` is decoded from state, so it is 1 from the first cycle after reset.
  - `in_valid` is ignored while `rst`=1.
- **Latency**
  - Operand accepted on edge E.
  - SHIFT occupies edges E+1 … E+BIN_W.
  - `out_valid` is high in the cycle after edge E+BIN_W. For BIN_W=14 that is 14 cycles after acceptance.
- **Throughput:** one conversion per BIN_W+2 cycles minimum (accept, BIN_W shifts, DONE with `out_ready`=1, return to IDLE).
- **Backpressure:** DONE is held indefinitely while `out_ready`=0. Outputs do not change.
- **Reset mid-operation:** `rst` in SHIFT or DONE aborts to IDLE. The partial result is discarded and `out_valid` drops on the next edge.
- **Simultaneous events:** `rst` wins over everything. `out_ready` while in IDLE or SHIFT has no effect.

## Configuration
- Macro: `BCD_OVF_EN`.
- **Defined:**
  - The sticky overflow register is compiled in.
  - It is set whenever a 1 shifts out of digit DIGITS−1, and is visible on `ovf` alongside `out_valid`.
  - `bcd` then holds the result mod 10^DIGITS.
- **Undefined:**
  - No overflow logic; `ovf` is tied to 0.
  - Truncated results are unflagged.

## Structure
- Shared package `bcd_pkg` holds:
  - the FSM state encoding (IDLE/SHIFT/DONE);
  - `BCD_DIGIT_W`=4;
  - `BCD_ADJ_THRESH`=5 and `BCD_ADJ_ADD`=3;
  - a helper to compute the bit-counter width from BIN_W.
- Sub-module `bcd_digit_adj`: a combinational 4-bit add-3-if-≥5 cell, instantiated DIGITS times by generate loop.
- The top level holds the FSM, the bit counter, the shift register, the output registers and the optional overflow logic.

## Test plan
- **Zero:** default params, `bin`=0, `out_ready`=1 → `out_valid` 14 cycles after acceptance, `bcd`=0x00000, `ovf`=0.
- **Exact values:** `bin`=4095, then 2730, then 16383 → `bcd`=0x04095, then 0x02730, then 0x16383; `in_ready` low for each 15-cycle busy window.
- **Backpressure and busy input:**
  - `bin`=201, `out_ready` held 0 for 6 cycles → `bcd`=0x00201 stable, `out_valid` held; IDLE one cycle after `out_ready`=1.
  - `in_valid` pulsed during SHIFT → ignored, result unchanged.
- **Mid-operation reset:** `rst` pulsed 5 cycles into SHIFT of `bin`=9999 → `out_valid`=0, `in_ready`=1 after the reset edge. A following `bin`=10 then yields 0x00010.
- **Overflow:** DIGITS=4, `BCD_OVF_EN` defined. `bin`=10000 → `bcd`=0x0000, `ovf`=1. `bin`=9999 → 0x9999, `ovf`=0.
- **Overflow compiled out:** DIGITS=4, `BCD_OVF_EN` undefined. `bin`=12345 → `bcd`=0x2345, `ovf`=0.
